// File: rtl/contador_cm_bcd.sv
// Ultrasonic range-finder controller: fires a trigger pulse, times the echo,
// and reports the distance in centimetres as a saturating 3-digit BCD value.
module contador_cm_bcd #(
  parameter int CICLOS_CM      = 2941,
  parameter int CICLOS_TRIGGER = 500,
  parameter int CICLOS_TIMEOUT = 2000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        medir,
  input  logic        echo,
  output logic        trigger,
  output logic [11:0] medida,
  output logic        pronto,
  output logic        timeout,
  output logic [3:0]  db_estado
);

  typedef enum logic [3:0] {
    ST_INICIAL     = 4'h0,
    ST_PREPARA     = 4'h1,
    ST_TRIGGER     = 4'h2,
    ST_ESPERA_ECHO = 4'h3,
    ST_MEDINDO     = 4'h4,
    ST_ARMAZENA    = 4'h5,
    ST_FINAL       = 4'h6,
    ST_ERRO        = 4'hF
  } estado_t;

  localparam int CNT_MAX = (CICLOS_TIMEOUT > CICLOS_TRIGGER) ? CICLOS_TIMEOUT : CICLOS_TRIGGER;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int DIV_W   = (CICLOS_CM > 1) ? $clog2(CICLOS_CM) : 1;

  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(CICLOS_TRIGGER - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(CICLOS_TIMEOUT - 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CICLOS_CM - 1);

  estado_t          estado_q, estado_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [11:0]      bcd_q, bcd_d;
  logic [11:0]      medida_q, medida_d;
  logic             conta;

  // Saturating BCD increment: 999 holds, otherwise ripple the decimal carry.
  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v != 12'h999) begin
      if (v[3:0] != 4'd9) begin
        r[3:0] = v[3:0] + 4'd1;
      end else begin
        r[3:0] = 4'd0;
        if (v[7:4] != 4'd9) begin
          r[7:4] = v[7:4] + 4'd1;
        end else begin
          r[7:4]  = 4'd0;
          r[11:8] = v[11:8] + 4'd1;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path infers a latch.
    estado_d = estado_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    bcd_d    = bcd_q;
    medida_d = medida_q;
    trigger  = 1'b0;
    pronto   = 1'b0;
    timeout  = 1'b0;
    conta    = 1'b0;

    unique case (estado_q)
      ST_INICIAL: if (medir) estado_d = ST_PREPARA;
      ST_PREPARA: begin
        cnt_d    = '0;
        div_d    = '0;
        bcd_d    = '0;
        estado_d = ST_TRIGGER;
      end
      ST_TRIGGER: begin
        trigger = 1'b1;
        if (cnt_q == TRIG_LAST) begin
          cnt_d    = '0;
          estado_d = ST_ESPERA_ECHO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ESPERA_ECHO: begin
        // The rising-edge cycle is already an echo-high cycle, so it is timed too.
        if (echo) begin
          conta    = 1'b1;
          cnt_d    = CNT_W'(1);
          estado_d = ST_MEDINDO;
        end else if (cnt_q == TMO_LAST) begin
          estado_d = ST_ERRO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_MEDINDO: begin
        if (!echo) begin
          estado_d = ST_ARMAZENA;
        end else begin
          conta = 1'b1;
          if (cnt_q == TMO_LAST) estado_d = ST_ERRO;
          else                   cnt_d    = cnt_q + 1'b1;
        end
      end
      ST_ARMAZENA: begin
        medida_d = bcd_q;
        estado_d = ST_FINAL;
      end
      ST_FINAL: begin
        pronto   = 1'b1;
        estado_d = ST_INICIAL;
      end
      ST_ERRO: begin
        timeout  = 1'b1;
        estado_d = ST_INICIAL;
      end
      default: estado_d = ST_INICIAL;
    endcase

    if (conta) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
        bcd_d = bcd_inc(bcd_q);
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= ST_INICIAL;
      cnt_q    <= '0;
      div_q    <= '0;
      bcd_q    <= '0;
      medida_q <= '0;
    end else begin
      // NOTE: non-blocking updates keep every register sampling pre-edge values.
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      bcd_q    <= bcd_d;
      medida_q <= medida_d;
    end
  end

  assign medida    = medida_q;
  assign db_estado = estado_q;

endmodule

// File: tb/tb_contador_cm_bcd.sv
// Directed bench for contador_cm_bcd, run with scaled-down cycle parameters
// so that saturation and both timeout paths fit in a short simulation.
module tb_contador_cm_bcd;

  localparam int CM   = 7;
  localparam int TRIG = 5;
  localparam int TMO  = 8000;

  logic        clock = 1'b0;
  logic        reset;
  logic        medir;
  logic        echo;
  logic        trigger;
  logic [11:0] medida;
  logic        pronto;
  logic        timeout;
  logic [3:0]  db_estado;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [11:0] last_med;

  contador_cm_bcd #(
    .CICLOS_CM     (CM),
    .CICLOS_TRIGGER(TRIG),
    .CICLOS_TIMEOUT(TMO)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .medir    (medir),
    .echo     (echo),
    .trigger  (trigger),
    .medida   (medida),
    .pronto   (pronto),
    .timeout  (timeout),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Invariants watched on every cycle; they only count when violated.
  always @(negedge clock) begin
    if (!reset && pronto && timeout) check("pronto_and_timeout", 1, 0);
    if (!reset && (trigger !== (db_estado == 4'h2))) check("trigger_outside_state", trigger, db_estado == 4'h2);
  end

  // From the PREPARA negedge: counts trigger-high cycles, ends on first ESPERA_ECHO negedge.
  task automatic trig_phase(input string tag, input bit poke_medir);
    int n = 0;
    @(negedge clock);
    while (trigger === 1'b1 && n < 1000) begin
      n++;
      if (poke_medir) medir = (n == 2);
      @(negedge clock);
    end
    check({tag, ".trig_len"}, n, TRIG);
    check({tag, ".espera"}, db_estado, 4'h3);
  endtask

  // Echo high for n_high cycles, then checks ARMAZENA and the FINAL pronto pulse.
  task automatic echo_phase(input int n_high, input logic [11:0] exp_med, input string tag);
    repeat (3) @(negedge clock);
    echo = 1'b1;
    repeat (n_high) @(negedge clock);
    check({tag, ".medindo"}, db_estado, 4'h4);
    echo = 1'b0;
    @(negedge clock);
    check({tag, ".armazena"}, db_estado, 4'h5);
    check({tag, ".medida_hold"}, medida, last_med);
    @(negedge clock);
    check({tag, ".pronto"}, pronto, 1);
    check({tag, ".timeout_low"}, timeout, 0);
    check({tag, ".medida"}, medida, exp_med);
    last_med = exp_med;
  endtask

  task automatic measure(input int n_high, input logic [11:0] exp_med, input string tag);
    @(negedge clock) medir = 1'b1;
    @(negedge clock) medir = 1'b0;
    check({tag, ".prepara"}, db_estado, 4'h1);
    trig_phase(tag, 1'b0);
    echo_phase(n_high, exp_med, tag);
    @(negedge clock);
    check({tag, ".pronto_pulse"}, pronto, 0);
    check({tag, ".inicial"}, db_estado, 4'h0);
  endtask

  initial begin
    int n;
    int seen;
    reset = 1'b1;
    medir = 1'b0;
    echo  = 1'b0;
    last_med = 12'h000;
    repeat (3) @(negedge clock);
    check("rst.estado", db_estado, 4'h0);
    check("rst.medida", medida, 12'h000);
    check("rst.outs", {trigger, pronto, timeout}, 3'b000);
    reset = 1'b0;
    @(negedge clock);
    check("idle.estado", db_estado, 4'h0);

    measure(20 * CM, 12'h020, "m20");
    measure(CM - 1, 12'h000, "m0");
    measure(10 * CM, 12'h010, "m10");
    measure(20 * CM - 1, 12'h019, "m19");
    measure(100 * CM, 12'h100, "m100");
    measure(7500, 12'h999, "msat");

    // Echo never rises: ERRO exactly TMO cycles after ESPERA_ECHO entry.
    @(negedge clock) medir = 1'b1;
    @(negedge clock) medir = 1'b0;
    trig_phase("tmo_rise", 1'b0);
    n = 0;
    while (timeout !== 1'b1 && n < 3 * TMO) begin
      @(negedge clock);
      n++;
    end
    check("tmo_rise.latency", n, TMO);
    check("tmo_rise.estado", db_estado, 4'hF);
    check("tmo_rise.pronto_low", pronto, 0);
    check("tmo_rise.medida", medida, last_med);
    @(negedge clock);
    check("tmo_rise.inicial", db_estado, 4'h0);
    check("tmo_rise.pulse", timeout, 0);

    // Echo stuck high: ERRO after TMO echo-high cycles.
    @(negedge clock) medir = 1'b1;
    @(negedge clock) medir = 1'b0;
    trig_phase("tmo_fall", 1'b0);
    echo = 1'b1;
    n = 0;
    while (timeout !== 1'b1 && n < 3 * TMO) begin
      @(negedge clock);
      n++;
    end
    echo = 1'b0;
    check("tmo_fall.latency", n, TMO);
    check("tmo_fall.medida", medida, last_med);
    @(negedge clock);
    check("tmo_fall.inicial", db_estado, 4'h0);

    // Reset in the middle of MEDINDO.
    @(negedge clock) medir = 1'b1;
    @(negedge clock) medir = 1'b0;
    trig_phase("rst_mid", 1'b0);
    echo = 1'b1;
    repeat (50) @(negedge clock);
    check("rst_mid.medindo", db_estado, 4'h4);
    reset = 1'b1;
    #1;
    check("rst_mid.async_estado", db_estado, 4'h0);
    check("rst_mid.async_medida", medida, 12'h000);
    last_med = 12'h000;
    @(negedge clock);
    reset = 1'b0;
    echo  = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clock);
      seen = seen | int'(pronto) | int'(timeout) | int'(db_estado != 4'h0);
    end
    check("rst_mid.quiet", seen, 0);
    measure(20 * CM, 12'h020, "rst_mid.next");

    // medir held high: back-to-back runs with one INICIAL cycle between them.
    @(negedge clock) medir = 1'b1;
    @(negedge clock);
    check("b2b.prepara1", db_estado, 4'h1);
    trig_phase("b2b.1", 1'b0);
    echo_phase(2 * CM, 12'h002, "b2b.1");
    @(negedge clock);
    check("b2b.inicial", db_estado, 4'h0);
    @(negedge clock);
    check("b2b.prepara2", db_estado, 4'h1);
    medir = 1'b0;
    trig_phase("b2b.2", 1'b1);
    medir = 1'b0;
    echo_phase(3 * CM + 2, 12'h003, "b2b.2");
    repeat (3) @(negedge clock);
    check("b2b.no_queue", db_estado, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
